// File: rtl/data_prefetcher_pkg.sv
// -----------------------------------------------------------------------------
// data_prefetcher_pkg
//
// Purpose: types and helpers shared by the stride data prefetcher and its
// outstanding request list.
//   rpt_state_t  - per-PC stride confidence state
//   rpt_entry_t  - one reference prediction table entry
//   ORL_EMPTY    - marker for "no address returning this cycle"
//   nextState    - confidence transition on an RPT hit
//   strideRetrains - whether a hit replaces the stored stride
// -----------------------------------------------------------------------------
package data_prefetcher_pkg;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    TRANSIENT = 2'd1,
    STEADY    = 2'd2,
    NOPRED    = 2'd3
  } rpt_state_t;

  // The tag is kept at full PC width (pc >> index bits); the unused upper bits
  // are constant zero and fall away in synthesis.
  typedef struct packed {
    logic       valid;
    logic [15:0] tag;
    logic [15:0] lastAddr;
    logic [15:0] stride;
    rpt_state_t  state;
  } rpt_entry_t;

  localparam logic [15:0] ORL_EMPTY = 16'hFFFF;

  function automatic rpt_state_t nextState(input rpt_state_t cur, input logic correct);
    rpt_state_t ns;
    case (cur)
      INIT:      ns = correct ? STEADY    : TRANSIENT;
      TRANSIENT: ns = correct ? STEADY    : NOPRED;
      STEADY:    ns = correct ? STEADY    : INIT;
      default:   ns = correct ? TRANSIENT : NOPRED;
    endcase
    return ns;
  endfunction

  // A wrong prediction relearns the stride, except from STEADY where one
  // miss only drops confidence and keeps the established stride.
  function automatic logic strideRetrains(input rpt_state_t cur, input logic correct);
    return !correct && (cur != STEADY);
  endfunction

endpackage

// File: rtl/prefetch_orl.sv
// -----------------------------------------------------------------------------
// prefetch_orl
//
// Purpose: outstanding request list. A MEM_LATENCY-deep 16-bit shift register
// that delays every address placed on the memory load port so that its output
// names the address whose data the fixed-latency memory returns this cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (all stages to ORL_EMPTY)
//   shiftIn   in   address issued this cycle, or ORL_EMPTY when idle
//   orlOutput out  address returning this cycle, ORL_EMPTY when none
// -----------------------------------------------------------------------------
module prefetch_orl
  import data_prefetcher_pkg::*;
#(
  parameter int MEM_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] shiftIn,
  output logic [15:0] orlOutput
);

  logic [15:0] stageReg [MEM_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stageReg[i] <= ORL_EMPTY;
      end
    end else begin
      stageReg[0] <= shiftIn;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stageReg[i] <= stageReg[i-1];
      end
    end
  end

  // An address shifted in at the end of cycle t is visible in the last stage
  // during cycle t + MEM_LATENCY.
  assign orlOutput = stageReg[MEM_LATENCY-1];

endmodule

// File: rtl/data_prefetcher.sv
// -----------------------------------------------------------------------------
// data_prefetcher
//
// Purpose: PC-indexed stride prefetcher beside the L1 data cache. Learns a
// stride per load PC in a direct-mapped reference prediction table, queues a
// one-ahead prefetch when a PC is in STEADY state, and issues it on the shared
// memory load port in a cycle with no demand load. An outstanding request list
// reports which address the memory returns each cycle.
//
// Optional build macro: PF_JMP_FLUSH_EN
//   defined   - jmp clears the pending prefetch and blocks issue that cycle
//   undefined - jmp is ignored
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   pc             in   PC of the load presented this cycle
//   dReadEnable    in   demand load valid this cycle
//   dAddress       in   demand load word address
//   memRequest     out  prefetch request valid (combinational)
//   requestAddress out  prefetch address
//   orlOutput      out  address returning from memory this cycle, FFFF if none
//   jmp            in   control-flow redirect this cycle
//   jmpAddr        in   redirect target (interface compatibility only)
// -----------------------------------------------------------------------------
module data_prefetcher
  import data_prefetcher_pkg::*;
#(
  parameter int MEM_LATENCY = 8,
  parameter int RPT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        dReadEnable,
  input  logic [15:0] dAddress,
  output logic        memRequest,
  output logic [15:0] requestAddress,
  output logic [15:0] orlOutput,
  input  logic        jmp,
  input  logic [11:0] jmpAddr
);

  localparam int IDX_W = $clog2(RPT_ENTRIES);

  // ---------------------------------------------------------------------------
  // RPT lookup (combinational read of the entry selected by the low PC bits)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rptIndex;
  logic [15:0]      rptTag;
  rpt_entry_t       rptRead [RPT_ENTRIES];
  rpt_entry_t       lookup;
  rpt_entry_t       entryNext;
  logic             lookupHit;
  logic             strideCorrect;
  logic [15:0]      predictedAddr;
  logic [15:0]      observedStride;
  logic             genPrefetch;
  logic [15:0]      prefetchAddr;

  assign rptIndex       = pc[IDX_W-1:0];
  assign rptTag         = pc >> IDX_W;
  assign lookup         = rptRead[rptIndex];
  assign lookupHit      = lookup.valid && (lookup.tag == rptTag);
  assign predictedAddr  = lookup.lastAddr + lookup.stride;
  assign strideCorrect  = (dAddress == predictedAddr);
  assign observedStride = dAddress - lookup.lastAddr;

  // A miss allocates a fresh INIT entry; a hit advances the confidence state.
  // last_addr always tracks the newest demand address.
  always_comb begin
    entryNext.valid    = 1'b1;
    entryNext.tag      = rptTag;
    entryNext.lastAddr = dAddress;
    entryNext.stride   = 16'h0000;
    entryNext.state    = INIT;
    if (lookupHit) begin
      entryNext.state  = nextState(lookup.state, strideCorrect);
      entryNext.stride = strideRetrains(lookup.state, strideCorrect) ? observedStride
                                                                     : lookup.stride;
    end
  end

  assign genPrefetch  = dReadEnable && lookupHit && (entryNext.state == STEADY) &&
                        (entryNext.stride != 16'h0000);
  assign prefetchAddr = dAddress + entryNext.stride;

  // One register per entry; only the indexed entry is written on a demand load.
  genvar gi;
  generate
    for (gi = 0; gi < RPT_ENTRIES; gi++) begin : genRpt
      rpt_entry_t entryReg;

      always_ff @(posedge clk) begin
        if (rst) begin
          entryReg <= '0;
        end else if (dReadEnable && (rptIndex == IDX_W'(gi))) begin
          entryReg <= entryNext;
        end
      end

      assign rptRead[gi] = entryReg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Redirect handling
  // ---------------------------------------------------------------------------
  logic jmpFlush;
  logic unusedInputs;

`ifdef PF_JMP_FLUSH_EN
  assign jmpFlush     = jmp;
  assign unusedInputs = ^jmpAddr;
`else
  assign jmpFlush     = 1'b0;
  assign unusedInputs = ^{jmp, jmpAddr};
`endif

  // ---------------------------------------------------------------------------
  // Pending prefetch: a single slot, newest prediction wins
  // ---------------------------------------------------------------------------
  logic        pendingValid;
  logic [15:0] pendingAddr;

  // Demand loads own the memory port; the prefetch only goes out when idle.
  assign memRequest     = pendingValid && !dReadEnable && !jmpFlush;
  assign requestAddress = pendingAddr;

  // genPrefetch needs a demand load and memRequest needs its absence, so the
  // two never compete at one edge; a redirect beats both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendingValid <= 1'b0;
      pendingAddr  <= 16'h0000;
    end else if (jmpFlush) begin
      pendingValid <= 1'b0;
    end else if (genPrefetch) begin
      pendingValid <= 1'b1;
      pendingAddr  <= prefetchAddr;
    end else if (memRequest) begin
      pendingValid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding request list
  // ---------------------------------------------------------------------------
  logic [15:0] orlIn;

  always_comb begin
    orlIn = ORL_EMPTY;
    if (dReadEnable) begin
      orlIn = dAddress;
    end else if (memRequest) begin
      orlIn = requestAddress;
    end
  end

  prefetch_orl #(
    .MEM_LATENCY(MEM_LATENCY)
  ) orl (
    .clk      (clk),
    .rst      (rst),
    .shiftIn  (orlIn),
    .orlOutput(orlOutput)
  );

endmodule

// File: tb/tb_data_prefetcher.sv
// -----------------------------------------------------------------------------
// tb_data_prefetcher
//
// Self-checking bench for data_prefetcher: directed scenarios (reset, stride
// training, port arbitration, ORL timing, wrap-around, redirect) followed by
// randomized loads. A table-driven reference model of the RPT, a one-slot
// pending prefetch and a queue standing in for the memory pipeline predict
// memRequest, requestAddress and orlOutput every cycle.
// Honors PF_JMP_FLUSH_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_data_prefetcher;

  localparam int LAT = 8;
  localparam int NENT = 16;

  localparam int S_INIT   = 0;
  localparam int S_TRANS  = 1;
  localparam int S_STEADY = 2;
  localparam int S_NOPRED = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        dReadEnable;
  logic [15:0] dAddress;
  logic        memRequest;
  logic [15:0] requestAddress;
  logic [15:0] orlOutput;
  logic        jmp;
  logic [11:0] jmpAddr;

  always #5 clk = ~clk;

  data_prefetcher #(
    .MEM_LATENCY(LAT),
    .RPT_ENTRIES(NENT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .dReadEnable   (dReadEnable),
    .dAddress      (dAddress),
    .memRequest    (memRequest),
    .requestAddress(requestAddress),
    .orlOutput     (orlOutput),
    .jmp           (jmp),
    .jmpAddr       (jmpAddr)
  );

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;
  bit modelValid = 1'b0;

  // Reference model state
  bit          mValid  [NENT];
  logic [15:0] mTag    [NENT];
  logic [15:0] mLast   [NENT];
  logic [15:0] mStride [NENT];
  int          mState  [NENT];
  bit          mPend;
  logic [15:0] mPendAddr;
  logic [15:0] orlQ [$];

  // Confidence transition tables indexed by current state
  int nextIfCorrect [4] = '{S_STEADY, S_STEADY, S_STEADY, S_TRANS};
  int nextIfWrong   [4] = '{S_TRANS,  S_NOPRED, S_INIT,   S_NOPRED};

  // Last sampled outputs, for directed checks
  logic        obsReq;
  logic [15:0] obsAddr;
  logic [15:0] obsOrl;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cycleNo, got, exp);
    end
  endtask

  function automatic bit flushes(input bit j);
`ifdef PF_JMP_FLUSH_EN
    return j;
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NENT; i++) begin
      mValid[i]  = 1'b0;
      mTag[i]    = 16'h0;
      mLast[i]   = 16'h0;
      mStride[i] = 16'h0;
      mState[i]  = S_INIT;
    end
    mPend     = 1'b0;
    mPendAddr = 16'h0;
    orlQ.delete();
    for (int i = 0; i < LAT; i++) orlQ.push_back(16'hFFFF);
  endtask

  task automatic modelEdge(input logic [15:0] p, input bit re, input logic [15:0] a, input bit j);
    bit          fl;
    bit          req;
    bit          gen;
    bit          correct;
    int          idx;
    logic [15:0] tg;
    logic [15:0] str;
    int          ns;
    fl  = flushes(j);
    req = mPend && !re && !fl;
    gen = 1'b0;
    str = 16'h0;
    // memory pipeline: newest at the front, returning address at the back
    orlQ.push_front(re ? a : (req ? mPendAddr : 16'hFFFF));
    void'(orlQ.pop_back());
    if (re) begin
      idx = int'(p) % NENT;
      tg  = p / 16'(NENT);
      if (mValid[idx] && mTag[idx] == tg) begin
        correct = (a == 16'(mLast[idx] + mStride[idx]));
        if (correct) begin
          ns  = nextIfCorrect[mState[idx]];
          str = mStride[idx];
        end else begin
          ns  = nextIfWrong[mState[idx]];
          str = (mState[idx] == S_STEADY) ? mStride[idx] : 16'(a - mLast[idx]);
        end
        gen          = (ns == S_STEADY) && (str != 16'h0);
        mState[idx]  = ns;
        mStride[idx] = str;
        mLast[idx]   = a;
      end else begin
        mValid[idx]  = 1'b1;
        mTag[idx]    = tg;
        mLast[idx]   = a;
        mStride[idx] = 16'h0;
        mState[idx]  = S_INIT;
      end
    end
    if (fl) begin
      mPend = 1'b0;
    end else if (gen) begin
      mPend     = 1'b1;
      mPendAddr = a + str;
    end else if (req) begin
      mPend = 1'b0;
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, compare, advance model.
  task automatic cycle(input bit r, input logic [15:0] p, input bit re,
                       input logic [15:0] a, input bit j);
    bit expReq;
    rst         = r;
    pc          = p;
    dReadEnable = re;
    dAddress    = a;
    jmp         = j;
    jmpAddr     = 12'($urandom);
    @(negedge clk);
    obsReq  = memRequest;
    obsAddr = requestAddress;
    obsOrl  = orlOutput;
    if (modelValid) begin
      expReq = mPend && !re && !flushes(j);
      checkVal("memRequest", 16'(obsReq), 16'(expReq));
      if (expReq) checkVal("requestAddress", obsAddr, mPendAddr);
      checkVal("orlOutput", obsOrl, orlQ[LAT-1]);
    end
    $display("cyc=%0d rst=%0d pc=%h rd=%0d addr=%h jmp=%0d req=%0d raddr=%h orl=%h",
             cycleNo, r, p, re, a, j, obsReq, obsAddr, obsOrl);
    if (r) begin
      modelReset();
      modelValid = 1'b1;
    end else if (modelValid) begin
      modelEdge(p, re, a, j);
    end
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic load(input logic [15:0] p, input logic [15:0] a);
    cycle(1'b0, p, 1'b1, a, 1'b0);
  endtask

  // Random stimulus streams
  logic [15:0] rPc     [6] = '{16'h0010, 16'h0020, 16'h0030, 16'h0011, 16'h0090, 16'h0021};
  logic [15:0] rAddr   [6];
  logic [15:0] rStride [6];
  logic [15:0] strideChoices [6] = '{16'h0000, 16'h0004, 16'hFFFC, 16'h0008, 16'h0001, 16'h0010};

  initial begin
    rst = 1'b1; pc = 16'h0; dReadEnable = 1'b0; dAddress = 16'h0; jmp = 1'b0; jmpAddr = 12'h0;

    // Reset
    cycle(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle();
      checkVal("rst_req", 16'(obsReq), 16'h0);
      checkVal("rst_orl", obsOrl, 16'hFFFF);
    end

    // Stride training
    load(16'h0010, 16'h0100); idle(); checkVal("train_req1", 16'(obsReq), 16'h0);
    load(16'h0010, 16'h0104); idle(); checkVal("train_req2", 16'(obsReq), 16'h0);
    load(16'h0010, 16'h0108); idle();
    checkVal("train_req3", 16'(obsReq), 16'h1);
    checkVal("train_addr", obsAddr, 16'h010C);
    idle(); checkVal("train_drop", 16'(obsReq), 16'h0);

    // Port arbitration
    load(16'h0050, 16'h0100);
    load(16'h0050, 16'h0104);
    load(16'h0050, 16'h0108);
    load(16'h0061, 16'h3000); checkVal("arb_busy1", 16'(obsReq), 16'h0);
    load(16'h0062, 16'h3004); checkVal("arb_busy2", 16'(obsReq), 16'h0);
    load(16'h0063, 16'h3008); checkVal("arb_busy3", 16'(obsReq), 16'h0);
    idle();
    checkVal("arb_issue", 16'(obsReq), 16'h1);
    checkVal("arb_addr", obsAddr, 16'h010C);
    idle(); checkVal("arb_drop", 16'(obsReq), 16'h0);
    for (int k = 2; k <= 8; k++) idle();
    checkVal("orl_prefetch", obsOrl, 16'h010C);

    // ORL timing for a single demand load
    for (int i = 0; i < 8; i++) idle();
    load(16'h0031, 16'h0200);
    for (int k = 1; k <= 9; k++) begin
      idle();
      if (k == 7) checkVal("orl_t7", obsOrl, 16'hFFFF);
      if (k == 8) checkVal("orl_t8", obsOrl, 16'h0200);
      if (k == 9) checkVal("orl_t9", obsOrl, 16'hFFFF);
    end

    // Wrap-around
    load(16'h0020, 16'hFFF4);
    load(16'h0020, 16'hFFF8);
    load(16'h0020, 16'hFFFC);
    idle();
    checkVal("wrap_req", 16'(obsReq), 16'h1);
    checkVal("wrap_addr", obsAddr, 16'h0000);

    // Redirect while a prefetch is pending
    load(16'h0010, 16'h0100);
    load(16'h0010, 16'h0104);
    load(16'h0010, 16'h0108);
    cycle(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
`ifdef PF_JMP_FLUSH_EN
    checkVal("jmp_req", 16'(obsReq), 16'h0);
    idle(); checkVal("jmp_after", 16'(obsReq), 16'h0);
`else
    checkVal("jmp_req", 16'(obsReq), 16'h1);
    checkVal("jmp_addr", obsAddr, 16'h010C);
`endif

    // Randomized traffic
    for (int s = 0; s < 6; s++) begin
      rAddr[s]   = 16'($urandom);
      rStride[s] = strideChoices[$urandom_range(0, 5)];
    end
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          re;
      bit          j;
      int          k;
      r  = ($urandom_range(0, 199) == 0);
      k  = int'($urandom_range(0, 5));
      re = ($urandom_range(0, 99) < 60);
      j  = ($urandom_range(0, 9) == 0);
      if (re) begin
        if ($urandom_range(0, 99) < 80) begin
          rAddr[k] = rAddr[k] + rStride[k];
        end else begin
          rAddr[k] = 16'($urandom);
          if ($urandom_range(0, 1) == 1) rStride[k] = strideChoices[$urandom_range(0, 5)];
        end
      end
      cycle(r, rPc[k], re, rAddr[k], j);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
